// File: rtl/aes128_encrypt_iter_pkg.sv
// ============================================================================
// Module   : aes128_encrypt_iter_pkg
// Brief    : Shared AES-128 definitions: FSM encoding, round constants and
//            forward GF(2^8) round primitives used by the iterative core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes128_encrypt_iter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned c_AES_NR     = 10;
    localparam logic [3:0]  c_RND_LAST   = 4'd10;

    function automatic logic [7:0] rcon_lookup(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Forward S-box computed as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x15  = gmul(x12, x3);
        x240 = gmul(gmul(gmul(x15, x15), gmul(x15, x15)), gmul(gmul(x15, x15), gmul(x15, x15)));
        x240 = gmul(x240, x240);
        inv  = gmul(gmul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = sbox(s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes128_encrypt_iter_if.sv
// ============================================================================
// Module   : aes128_encrypt_iter_if
// Brief    : Block-in / block-out valid-ready bundle for the AES-128 core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes128_encrypt_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;

    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext, busy
    );

    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext, busy
    );
endinterface

`default_nettype wire

// File: rtl/aes128_encrypt_iter_key_step.sv
// ============================================================================
// Module   : aes_key_expand_step
// Brief    : One combinational AES-128 key-schedule step (four new words).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_key_expand_step
    import aes128_encrypt_iter_pkg::*;
(
    input  wire logic [127:0] rk_in,
    input  wire logic [7:0]   rcon,
    output logic      [127:0] rk_out
);

    logic [31:0] w_rot;
    logic [31:0] w_sub;
    logic [31:0] w0, w1, w2, w3;

    assign w_rot = {rk_in[23:0], rk_in[31:24]};

    generate
        for (genvar b = 0; b < 4; b++) begin : g_sub
            assign w_sub[31 - 8 * b -: 8] = sbox(w_rot[31 - 8 * b -: 8]);
        end
    endgenerate

    assign w0 = rk_in[127:96] ^ w_sub ^ {rcon, 24'h000000};
    assign w1 = rk_in[95:64]  ^ w0;
    assign w2 = rk_in[63:32]  ^ w1;
    assign w3 = rk_in[31:0]   ^ w2;

    assign rk_out = {w0, w1, w2, w3};

endmodule

`default_nettype wire

// File: rtl/aes128_encrypt_iter.sv
// ============================================================================
// Module   : aes128_encrypt_iter
// Brief    : Iterative AES-128 encryptor, one round per clock, on-the-fly keys.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes128_encrypt_iter
    import aes128_encrypt_iter_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst_n,
    aes128_encrypt_iter_if.slave  bus
);

    state_e       fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] ct_q, ct_d;
    logic         ov_q, ov_d;

    logic [7:0]   w_rcon;
    logic [127:0] w_rk_next;
    logic [127:0] w_sr;
    logic [127:0] w_round;

    assign w_rcon = rcon_lookup(rnd_q);

    aes_key_expand_step u_key_step (
        .rk_in  (rk_q),
        .rcon   (w_rcon),
        .rk_out (w_rk_next)
    );

    // Final round bypasses MixColumns
    assign w_sr    = sub_shift(state_q);
    assign w_round = ((rnd_q == c_RND_LAST) ? w_sr : mix_columns(w_sr)) ^ w_rk_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            rnd_q   <= 4'd0;
            state_q <= '0;
            rk_q    <= '0;
            ct_q    <= '0;
            ov_q    <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            ct_q    <= ct_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        rk_d    = rk_q;
        ct_d    = ct_q;
        ov_d    = ov_q;
        case (fsm_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = bus.plaintext ^ bus.key;
                    rk_d    = bus.key;
                    rnd_d   = 4'd1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                if (rnd_q == 4'd0 || rnd_q > c_RND_LAST) begin
                    rnd_d = 4'd0;
                    fsm_d = IDLE;
                end else begin
                    state_d = w_round;
                    rk_d    = w_rk_next;
                    rnd_d   = rnd_q + 4'd1;
                    if (rnd_q == c_RND_LAST) begin
                        ct_d  = w_round;
                        ov_d  = 1'b1;
                        fsm_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    ov_d  = 1'b0;
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready   = (fsm_q == IDLE);
    assign bus.busy       = (fsm_q == ROUND) || (fsm_q == DONE);
    assign bus.out_valid  = ov_q;
    assign bus.ciphertext = ct_q;

endmodule

`default_nettype wire

// File: tb/tb_aes128_encrypt_iter.sv
// ============================================================================
// Module   : tb_aes128_encrypt_iter
// Brief    : Directed FIPS-197 vector bench for the iterative AES-128 core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes128_encrypt_iter;

    localparam logic [127:0] c_K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_RK2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    aes128_encrypt_iter_if bus ();

    aes128_encrypt_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Returns number of edges until out_valid is seen, or -1 if the budget expires
    task automatic wait_ov(input int budget, output int n);
        bit seen;
        seen = 1'b0;
        n    = -1;
        for (int i = 1; i <= budget; i++) begin
            if (!seen) begin
                @(posedge clk);
                @(negedge clk);
                if (bus.out_valid === 1'b1) begin
                    seen = 1'b1;
                    n    = i;
                end
            end
        end
    endtask

    task automatic start_block(input logic [127:0] pt, input logic [127:0] k);
        bus.in_valid  = 1'b1;
        bus.plaintext = pt;
        bus.key       = k;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.ciphertext !== 128'h0) begin errors++; $display("FAIL reset_ct got %h want 0", bus.ciphertext); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_fips_c1();
        int n;
        start_block(c_P1, c_K1);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL c1_busy got %b want 1", bus.busy); end
        wait_ov(30, n);
        checks++; if (n + 1 !== 11) begin errors++; $display("FAIL c1_latency got %0d want 11", n + 1); end
        checks++; if (bus.ciphertext !== c_C1) begin errors++; $display("FAIL c1_ct got %h want %h", bus.ciphertext, c_C1); end
        handshake();
    endtask

    task automatic test_fips_b();
        int n;
        start_block(c_P2, c_K2);
        wait_ov(30, n);
        checks++; if (bus.ciphertext !== c_C2) begin errors++; $display("FAIL b_ct got %h want %h", bus.ciphertext, c_C2); end
        checks++; if (dut.rk_q !== c_RK2) begin errors++; $display("FAIL b_rk10 got %h want %h", dut.rk_q, c_RK2); end
        handshake();
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        bad = 0;
        start_block(c_P1, c_K1);
        wait_ov(30, n);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.ciphertext !== c_C1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got ov=%b ct=%h rdy=%b want ov=1 ct=%h rdy=0",
                         i, bus.out_valid, bus.ciphertext, bus.in_ready, c_C1);
            end
        end
        handshake();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_ov got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got %b want 1", bus.in_ready); end
        checks++; if (bus.ciphertext !== c_C1) begin errors++; $display("FAIL bp_ct_kept got %h want %h", bus.ciphertext, c_C1); end
    endtask

    task automatic test_input_busy();
        int n;
        start_block(c_P1, c_K1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.plaintext = c_P2;
        bus.key       = c_K2;
        wait_ov(30, n);
        checks++; if (bus.ciphertext !== c_C1) begin errors++; $display("FAIL busy_v1_ct got %h want %h", bus.ciphertext, c_C1); end
        handshake();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL busy_idle_rdy got %b want 1", bus.in_ready); end
        wait_ov(30, n);
        bus.in_valid = 1'b0;
        checks++; if (n !== 11) begin errors++; $display("FAIL busy_v2_latency got %0d want 11", n); end
        checks++; if (bus.ciphertext !== c_C2) begin errors++; $display("FAIL busy_v2_ct got %h want %h", bus.ciphertext, c_C2); end
        handshake();
    endtask

    task automatic test_reset_mid();
        int n;
        start_block(c_P1, c_K1);
        for (int i = 0; i < 4; i++) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ov got %b want 0", bus.out_valid); end
        checks++; if (bus.ciphertext !== 128'h0) begin errors++; $display("FAIL rstmid_ct got %h want 0", bus.ciphertext); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_rdy got %b want 1", bus.in_ready); end
        @(negedge clk);
        start_block(c_P1, c_K1);
        wait_ov(30, n);
        checks++; if (bus.ciphertext !== c_C1) begin errors++; $display("FAIL rstmid_rerun_ct got %h want %h", bus.ciphertext, c_C1); end
        handshake();
    endtask

    task automatic test_back_to_back();
        int edge_n;
        int last;
        int pulses;
        edge_n = 0;
        last   = 0;
        pulses = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.plaintext = c_P1;
        bus.key       = c_K1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            edge_n++;
            if (bus.out_valid === 1'b1) begin
                pulses++;
                checks++; if (bus.ciphertext !== c_C1) begin errors++; $display("FAIL b2b_ct got %h want %h", bus.ciphertext, c_C1); end
                if (last > 0) begin
                    checks++; if (edge_n - last !== 12) begin errors++; $display("FAIL b2b_period got %0d want 12", edge_n - last); end
                end
                last = edge_n;
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses got %0d want 3", pulses); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.plaintext = '0;
        bus.key       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_backpressure();
        test_input_busy();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes128_encrypt_iter.md
Name: aes128_encrypt_iter

Overview:
Iterative AES-128 encryption core, the forward counterpart of the existing decryption round datapath. It executes one cipher round per clock through a shared round datapath: SubBytes, ShiftRows, MixColumns and AddRoundKey. Round keys are expanded on the fly from the cipher key. A valid/ready handshake sits on the input side and on the output side, so the core drops between the key/plaintext source and the ciphertext consumer.

Parameters:
None. The core is fixed to AES-128: Nk=4, Nr=10.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  plaintext and key are valid
in_ready  output  1  core can accept a block (high only in IDLE)
plaintext  input  128  block to encrypt; [127:120] = byte 0, column-major per FIPS-197
key  input  128  cipher key; same byte order
out_valid  output  1  ciphertext is valid
out_ready  input  1  consumer accepts the ciphertext
ciphertext  output  128  encrypted block; same byte order
busy  output  1  high in ROUND or DONE

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, round counter=0, state register=0, round-key register=0.
  - ciphertext=0, out_valid=0, busy=0, in_ready=1 once rst_n=1.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready (cycle T): state_reg <= plaintext ^ key; rk_reg <= key; rnd <= 1; go to ROUND.
- ROUND (rnd = 1..10), one round per cycle:
  - rk_next = key_expand_step(rk_reg, Rcon[rnd]).
  - rnd 1..9: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ rk_next.
  - rnd 10: MixColumns is skipped.
  - Each cycle: rk_reg <= rk_next, rnd <= rnd+1.
  - After rnd 10: ciphertext <= result, out_valid <= 1, go to DONE.
- Latency: out_valid rises at edge T+11, counting the capture edge as T+1, with the rounds on edges T+2..T+11.
- DONE:
  - ciphertext and out_valid held stable until out_ready=1.
  - On out_valid&out_ready: out_valid <= 0, go to IDLE. ciphertext keeps its last value.
  - No new input is accepted in the same cycle: in_ready is low in DONE. Throughput is one block per 12 cycles minimum.
- out_ready already high when DONE is entered: the handshake completes on the first DONE cycle.
- in_valid is ignored outside IDLE. plaintext and key are sampled only at the capture edge, so changes afterwards have no effect.
- Reset asserted mid-operation: the core aborts immediately to reset values. No partial ciphertext is exposed and out_valid stays 0.
- Round counter: 4 bits. Values 0 and 11..15 are unreachable. If reached, the FSM returns to IDLE.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 (hex).
- Key step: w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,00,00,00}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- S-box usage: 16 forward S-boxes for the state plus 4 for the key word, all combinational. There is no register between SubBytes and AddRoundKey.

Decomposition:
- Shared include `aes_defs.vh`, holding:
  - FSM state encodings (IDLE=2'd0, ROUND=2'd1, DONE=2'd2);
  - AES_NR=10;
  - the Rcon function;
  - the forward S-box function, shared with the existing inverse S-box file.
- Sub-module aes_key_expand_step: combinational, inputs rk_in[127:0] and rcon[7:0], output rk_out[127:0]. The decryption key schedule reuses it.
- The round datapath reuses the existing SubBytes, ShiftRows, MixColumns and AddRoundKey modules.

Test Plan:
1. FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid exactly 11 edges after acceptance.
2. FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. Internal rk after round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
3. Backpressure: hold out_ready=0 for 20 cycles after out_valid -> ciphertext and out_valid stable and in_ready=0 throughout. Then one cycle of out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
4. Input during busy: present the vector 2 inputs with in_valid=1 at rounds 3..9 of vector 1 -> ignored, vector 1 result is correct. Vector 2 is then accepted only after the DONE handshake and also yields its correct result.
5. Reset mid-operation: drop rst_n for 1 cycle at round 5 -> outputs immediately 0, busy=0. After release, in_ready=1 and a fresh vector 1 run produces 69c4e0d8...c55a.
6. Back-to-back: out_ready tied 1 and in_valid tied 1 with the same vector -> out_valid pulses for one cycle every 12 cycles, each with the correct ciphertext.
